// File: rtl/roic_reg_sequencer_if.sv
// Serializer-side bus of the ROIC register sequencer: one register word out,
// chip-select and parallel readback word back.
interface roic_reg_sequencer_if;
  logic [7:0]   spi_address;
  logic [15:0]  spi_data;
  logic         spi_ready;
  logic         spi_sen;
  logic [191:0] spi_sdout_word;

  // Sequencer side: issues words, watches chip select, reads back.
  modport master (
    output spi_address,
    output spi_data,
    output spi_ready,
    input  spi_sen,
    input  spi_sdout_word
  );

  // Serializer side.
  modport slave (
    input  spi_address,
    input  spi_data,
    input  spi_ready,
    output spi_sen,
    output spi_sdout_word
  );
endinterface

// File: rtl/roic_reg_sequencer.sv
// ROIC register sequencer: replays a host-loaded table of {addr,data} writes
// to the SPI serializer, one word per entry, waiting for each chip-select
// cycle to complete and capturing the readback word it produces.
module roic_reg_sequencer #(
  parameter int DEPTH          = 32,
  parameter int AW             = 5,
  parameter int READY_HIGH_CYC = 4,
  parameter int GAP_CYC        = 16,
  parameter int TIMEOUT_CYC    = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  tbl_we,
  input  logic [AW-1:0]         tbl_waddr,
  input  logic [23:0]           tbl_wdata,
  input  logic [AW:0]           seq_len,
  input  logic                  start,
  input  logic                  abort,
  roic_reg_sequencer_if.master  spi,
  output logic                  busy,
  output logic                  done,
  output logic                  err_timeout,
  output logic [AW-1:0]         cur_idx,
  output logic [191:0]          rb_word,
  output logic                  rb_valid
);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_PULSE, S_WAIT_SEN_LO, S_WAIT_SEN_HI,
    S_CAPTURE, S_GAP, S_FINISH, S_ERR
  } state_t;

  localparam int CNT_MAX = (GAP_CYC > READY_HIGH_CYC) ? GAP_CYC : READY_HIGH_CYC;
  localparam int CW      = $clog2(CNT_MAX) + 1;
  localparam int TW      = $clog2(TIMEOUT_CYC) + 1;

  localparam logic [CW-1:0] CNT_ONE      = CW'(1);
  localparam logic [CW-1:0] READY_LAST   = CW'(READY_HIGH_CYC - 1);
  localparam logic [CW-1:0] GAP_LAST     = CW'(GAP_CYC - 1);
  // Readback settles onto spi_sdout_word two cycles after SEN returns idle.
  localparam logic [CW-1:0] CAPTURE_LAST = CW'(1);
  localparam logic [TW-1:0] TCNT_ONE     = TW'(1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [AW:0]   IDX_ONE      = (AW+1)'(1);
  localparam logic [AW:0]   DEPTH_W      = (AW+1)'(DEPTH);

  state_t        state;
  logic [23:0]   tbl [DEPTH];
  logic [AW:0]   len;
  logic [AW:0]   idx;
  logic [CW-1:0] cnt;
  logic [TW-1:0] tcnt;
  logic          abort_q;
  logic [7:0]    address_q;
  logic [15:0]   data_q;
  logic          ready_q;
  logic          abort_now;

  assign abort_now       = abort | abort_q;
  assign spi.spi_address = address_q;
  assign spi.spi_data    = data_q;
  assign spi.spi_ready   = ready_q;

  // Host table write port, one-cycle latency.
  // NOTE: the table is plain storage with no reset; its contents are simply
  // undefined until the host loads them, which keeps it mappable to RAM.
  always_ff @(posedge clk) begin
    if (tbl_we) tbl[tbl_waddr] <= tbl_wdata;
  end

  // Sequencer FSM with registered outputs.
  // NOTE: every register here is assigned with <= so all state updates see
  // the values from before the edge, regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      len         <= '0;
      idx         <= '0;
      cnt         <= '0;
      tcnt        <= '0;
      abort_q     <= 1'b0;
      address_q   <= '0;
      data_q      <= '0;
      ready_q     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err_timeout <= 1'b0;
      cur_idx     <= '0;
      rb_word     <= '0;
      rb_valid    <= 1'b0;
    end else begin
      done     <= 1'b0;
      rb_valid <= 1'b0;
      if (abort && state != S_IDLE) abort_q <= 1'b1;

      case (state)
        S_IDLE: begin
          abort_q <= 1'b0;
          if (start && !abort) begin
            len         <= (seq_len > DEPTH_W) ? DEPTH_W : seq_len;
            idx         <= '0;
            err_timeout <= 1'b0;
            busy        <= 1'b1;
            if (seq_len == '0) begin
              done  <= 1'b1;
              state <= S_FINISH;
            end else begin
              state <= S_LOAD;
            end
          end
        end

        S_LOAD: begin
          if (abort_now) begin
            done  <= 1'b1;
            state <= S_FINISH;
          end else begin
            address_q <= tbl[idx[AW-1:0]][23:16];
            data_q    <= tbl[idx[AW-1:0]][15:0];
            cur_idx   <= idx[AW-1:0];
            ready_q   <= 1'b1;
            cnt       <= '0;
            state     <= S_PULSE;
          end
        end

        S_PULSE: begin
          if (abort_now) begin
            ready_q <= 1'b0;
            done    <= 1'b1;
            state   <= S_FINISH;
          end else if (cnt == READY_LAST) begin
            ready_q <= 1'b0;
            tcnt    <= '0;
            state   <= S_WAIT_SEN_LO;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        S_WAIT_SEN_LO: begin
          if (!spi.spi_sen) begin
            tcnt  <= '0;
            state <= S_WAIT_SEN_HI;
          end else if (tcnt >= TIMEOUT_LAST) begin
            err_timeout <= 1'b1;
            done        <= 1'b1;
            state       <= S_ERR;
          end else if (tcnt != '1) begin
            tcnt <= tcnt + TCNT_ONE;
          end
        end

        S_WAIT_SEN_HI: begin
          if (spi.spi_sen) begin
            cnt   <= '0;
            state <= S_CAPTURE;
          end else if (tcnt >= TIMEOUT_LAST) begin
            err_timeout <= 1'b1;
            done        <= 1'b1;
            state       <= S_ERR;
          end else if (tcnt != '1) begin
            tcnt <= tcnt + TCNT_ONE;
          end
        end

        S_CAPTURE: begin
          if (cnt == CAPTURE_LAST) begin
            rb_word  <= spi.spi_sdout_word;
            rb_valid <= 1'b1;
            cnt      <= '0;
            if (abort_now) begin
              done  <= 1'b1;
              state <= S_FINISH;
            end else begin
              state <= S_GAP;
            end
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        S_GAP: begin
          if (abort_now) begin
            done  <= 1'b1;
            state <= S_FINISH;
          end else if (cnt == GAP_LAST) begin
            if (idx + IDX_ONE == len) begin
              done  <= 1'b1;
              state <= S_FINISH;
            end else begin
              idx   <= idx + IDX_ONE;
              state <= S_LOAD;
            end
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        S_FINISH: begin
          busy    <= 1'b0;
          abort_q <= 1'b0;
          state   <= S_IDLE;
        end

        S_ERR: begin
          busy    <= 1'b0;
          ready_q <= 1'b0;
          abort_q <= 1'b0;
          state   <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_roic_reg_sequencer.sv
// Self-checking bench for roic_reg_sequencer: a behavioural serializer model
// answers each word with a random chip-select cycle and readback word, and a
// table model predicts which words must be issued and in what order.
module tb_roic_reg_sequencer;
  localparam int DEPTH = 32;
  localparam int AW    = 5;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           tbl_we = 1'b0;
  logic [AW-1:0]  tbl_waddr = '0;
  logic [23:0]    tbl_wdata = '0;
  logic [AW:0]    seq_len = '0;
  logic           start = 1'b0;
  logic           abort = 1'b0;
  logic           busy, done, err_timeout, rb_valid;
  logic [AW-1:0]  cur_idx;
  logic [191:0]   rb_word;

  roic_reg_sequencer_if spi_if();

  roic_reg_sequencer #(
    .DEPTH(DEPTH), .AW(AW), .READY_HIGH_CYC(4), .GAP_CYC(16), .TIMEOUT_CYC(256)
  ) u_dut (
    .clk(clk), .reset(reset), .tbl_we(tbl_we), .tbl_waddr(tbl_waddr),
    .tbl_wdata(tbl_wdata), .seq_len(seq_len), .start(start), .abort(abort),
    .spi(spi_if), .busy(busy), .done(done), .err_timeout(err_timeout),
    .cur_idx(cur_idx), .rb_word(rb_word), .rb_valid(rb_valid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cycle = 0;

  // Reference model of the table and the expected replay of one run.
  logic [23:0]  model_tbl [DEPTH];
  logic [23:0]  exp_entries [$];
  logic [191:0] exp_rb [$];

  // Observations collected by the monitor.
  logic [23:0]  rise_log [$];
  logic [23:0]  fall_log [$];
  int           idx_log [$];
  int           width_log [$];
  logic [191:0] rb_log [$];
  int           done_cnt = 0;
  int           ready_width = 0;
  bit           ready_seen = 0;
  logic         ready_prev = 1'b0;
  int           fall_cycle = 0;
  int           done_cycle = 0;

  bit ser_enable = 0;
  bit ser_hang = 0;

  // Monitor: samples DUT outputs on the falling clock edge.
  always @(negedge clk) begin
    cycle++;
    if (spi_if.spi_ready === 1'b1 && ready_prev !== 1'b1) begin
      rise_log.push_back({spi_if.spi_address, spi_if.spi_data});
      idx_log.push_back(int'(cur_idx));
      ready_width = 0;
    end
    if (spi_if.spi_ready === 1'b1) begin
      ready_width++;
      ready_seen = 1;
    end
    if (spi_if.spi_ready !== 1'b1 && ready_prev === 1'b1) begin
      width_log.push_back(ready_width);
      fall_log.push_back({spi_if.spi_address, spi_if.spi_data});
      fall_cycle = cycle;
    end
    if (rb_valid === 1'b1) rb_log.push_back(rb_word);
    if (done === 1'b1) begin
      done_cnt++;
      done_cycle = cycle;
    end
    ready_prev = spi_if.spi_ready;
  end

  // Serializer model: after each spi_ready fall, run one chip-select cycle of
  // random length and present a fresh random readback word as SEN goes idle.
  initial begin
    logic [191:0] word;
    spi_if.spi_sen = 1'b1;
    spi_if.spi_sdout_word = '0;
    forever begin
      @(negedge spi_if.spi_ready);
      if (ser_enable && !ser_hang) begin
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1 spi_if.spi_sen = 1'b0;
        repeat ($urandom_range(2, 8)) @(posedge clk);
        #1;
        word = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        spi_if.spi_sdout_word = word;
        exp_rb.push_back(word);
        spi_if.spi_sen = 1'b1;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic step(int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic clear_logs();
    rise_log.delete(); fall_log.delete(); idx_log.delete(); width_log.delete();
    rb_log.delete(); exp_rb.delete(); exp_entries.delete();
    done_cnt = 0; ready_seen = 0;
  endtask

  task automatic write_entry(int a, logic [23:0] v);
    tbl_we = 1'b1; tbl_waddr = a[AW-1:0]; tbl_wdata = v;
    step();
    tbl_we = 1'b0;
    model_tbl[a] = v;
  endtask

  task automatic pulse_start(int len);
    seq_len = (AW+1)'(len);
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Expected replay: the first min(len, DEPTH) table entries, in order.
  task automatic plan_run(int len);
    int n;
    n = (len > DEPTH) ? DEPTH : len;
    for (int i = 0; i < n; i++) exp_entries.push_back(model_tbl[i]);
  endtask

  task automatic wait_done(string name, int bound);
    bit ok;
    ok = 0;
    for (int i = 0; i < bound; i++) begin
      if (done_cnt > 0) begin
        ok = 1;
        break;
      end
      step();
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s_done_timeout: no done within %0d cycles", name, bound);
    end
  endtask

  // Compares a completed replay against the planned entries and the
  // readback words the serializer model produced.
  task automatic verify_replay(string name);
    int n;
    n = exp_entries.size();
    checks++;
    if (width_log.size() != n) begin
      failures++;
      $display("FAIL %s_word_count: got %0d expected %0d", name, width_log.size(), n);
    end
    for (int i = 0; i < n && i < width_log.size() && i < rise_log.size() && i < fall_log.size(); i++) begin
      checks++;
      if (width_log[i] != 4) begin
        failures++;
        $display("FAIL %s_ready_width[%0d]: got %0d expected 4", name, i, width_log[i]);
      end
      checks++;
      if (rise_log[i] !== exp_entries[i] || fall_log[i] !== exp_entries[i]) begin
        failures++;
        $display("FAIL %s_word[%0d]: got %h/%h expected %h", name, i, rise_log[i], fall_log[i], exp_entries[i]);
      end
      checks++;
      if (idx_log[i] != i) begin
        failures++;
        $display("FAIL %s_cur_idx[%0d]: got %0d expected %0d", name, i, idx_log[i], i);
      end
    end
    checks++;
    if (rb_log.size() != n || exp_rb.size() != n) begin
      failures++;
      $display("FAIL %s_rb_count: got %0d expected %0d", name, rb_log.size(), n);
    end
    for (int i = 0; i < rb_log.size() && i < exp_rb.size(); i++) begin
      checks++;
      if (rb_log[i] !== exp_rb[i]) begin
        failures++;
        $display("FAIL %s_rb_word[%0d]: got %h expected %h", name, i, rb_log[i], exp_rb[i]);
      end
    end
    checks++;
    if (done_cnt != 1 || err_timeout !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL %s_end_state: got done_cnt=%0d err=%b busy=%b expected 1/0/0",
               name, done_cnt, err_timeout, busy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(3);
    reset = 1'b0;
    step();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || err_timeout !== 1'b0 || rb_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags: got busy=%b done=%b err=%b rb_valid=%b expected 0", busy, done, err_timeout, rb_valid);
    end
    checks++;
    if (spi_if.spi_ready !== 1'b0 || spi_if.spi_address !== 8'h00 || spi_if.spi_data !== 16'h0000) begin
      failures++;
      $display("FAIL reset_spi: got ready=%b addr=%h data=%h expected 0", spi_if.spi_ready, spi_if.spi_address, spi_if.spi_data);
    end
    checks++;
    if (cur_idx !== '0 || rb_word !== '0) begin
      failures++;
      $display("FAIL reset_idx_rb: got cur_idx=%0d rb_word=%h expected 0", cur_idx, rb_word);
    end
  endtask

  task automatic test_basic();
    bit seen;
    write_entry(0, 24'h01_1234);
    write_entry(1, 24'h02_ABCD);
    write_entry(2, 24'h10_0001);
    clear_logs();
    plan_run(3);
    pulse_start(3);
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (spi_if.spi_ready === 1'b1) seen = 1;
      else step();
    end
    // Overwrite the entry in flight; the issued word must not change.
    write_entry(0, 24'hFF_FFFF);
    wait_done("basic", 600);
    step(2);
    verify_replay("basic");
  endtask

  task automatic test_random();
    int len;
    for (int it = 0; it < 3; it++) begin
      len = $urandom_range(1, 6);
      for (int i = 0; i < len; i++) write_entry(i, 24'($urandom()));
      clear_logs();
      plan_run(len);
      pulse_start(len);
      wait_done("random", 1000);
      step(2);
      verify_replay("random");
    end
  endtask

  task automatic test_zero_len();
    clear_logs();
    pulse_start(0);
    step();
    checks++;
    if (done_cnt != 1) begin
      failures++;
      $display("FAIL zero_len_done: got %0d done pulses within 2 cycles expected 1", done_cnt);
    end
    step(3);
    checks++;
    if (ready_seen || busy !== 1'b0 || done_cnt != 1) begin
      failures++;
      $display("FAIL zero_len_quiet: got ready_seen=%0d busy=%b done_cnt=%0d expected 0/0/1", ready_seen, busy, done_cnt);
    end
  endtask

  task automatic test_start_abort();
    clear_logs();
    abort = 1'b1;
    pulse_start(2);
    abort = 1'b0;
    step(3);
    checks++;
    if (busy !== 1'b0 || done_cnt != 0 || ready_seen) begin
      failures++;
      $display("FAIL start_abort_ignored: got busy=%b done_cnt=%0d ready_seen=%0d expected 0/0/0", busy, done_cnt, ready_seen);
    end
  endtask

  task automatic test_timeout();
    int waited;
    ser_hang = 1;
    clear_logs();
    pulse_start(2);
    wait_done("timeout", 800);
    waited = done_cycle - fall_cycle;
    checks++;
    if (err_timeout !== 1'b1) begin
      failures++;
      $display("FAIL timeout_err: got %b expected 1", err_timeout);
    end
    checks++;
    if (waited < 256 || waited > 258) begin
      failures++;
      $display("FAIL timeout_latency: got %0d cycles expected 256..258", waited);
    end
    step(2);
    checks++;
    if (busy !== 1'b0 || width_log.size() != 1 || done_cnt != 1) begin
      failures++;
      $display("FAIL timeout_end: got busy=%b words=%0d done_cnt=%0d expected 0/1/1", busy, width_log.size(), done_cnt);
    end
    ser_hang = 0;
    clear_logs();
    plan_run(1);
    pulse_start(1);
    checks++;
    if (err_timeout !== 1'b0) begin
      failures++;
      $display("FAIL timeout_clear_on_start: got %b expected 0", err_timeout);
    end
    wait_done("after_timeout", 600);
    step(2);
    verify_replay("after_timeout");
  endtask

  task automatic test_abort();
    bit hit;
    for (int i = 0; i < 4; i++) write_entry(i, 24'($urandom()));
    clear_logs();
    plan_run(2);
    pulse_start(4);
    hit = 0;
    for (int i = 0; i < 600 && !hit; i++) begin
      if (rise_log.size() == 2 && spi_if.spi_sen === 1'b0) hit = 1;
      else step();
    end
    checks++;
    if (!hit) begin
      failures++;
      $display("FAIL abort_window: got no second-word SEN low expected one");
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    wait_done("abort", 600);
    step(20);
    verify_replay("abort");
  endtask

  task automatic test_busy_start_and_reset();
    bit seen;
    for (int i = 0; i < 3; i++) write_entry(i, 24'($urandom()));
    clear_logs();
    plan_run(3);
    pulse_start(3);
    step(5);
    pulse_start(7);
    wait_done("busy_start", 1000);
    step(2);
    verify_replay("busy_start");

    clear_logs();
    pulse_start(2);
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (spi_if.spi_ready === 1'b1) seen = 1;
      else step();
    end
    ser_enable = 0;
    reset = 1'b1;
    step();
    checks++;
    if (spi_if.spi_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || !seen) begin
      failures++;
      $display("FAIL reset_mid_pulse: got ready=%b busy=%b done=%b in_pulse=%0d expected 0/0/0/1",
               spi_if.spi_ready, busy, done, seen);
    end
    reset = 1'b0;
    step(10);
    checks++;
    if (done_cnt != 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_no_done: got done_cnt=%0d busy=%b expected 0/0", done_cnt, busy);
    end
    ser_enable = 1;
  endtask

  task automatic test_full_table();
    for (int i = 0; i < DEPTH; i++) write_entry(i, 24'($urandom()));
    clear_logs();
    plan_run(32);
    pulse_start(32);
    wait_done("full", 3000);
    step(2);
    verify_replay("full");

    // seq_len beyond the table clamps to the full table.
    clear_logs();
    plan_run(45);
    pulse_start(45);
    wait_done("clamp", 3000);
    step(2);
    verify_replay("clamp");
  endtask

  initial begin
    test_reset();
    ser_enable = 1;
    test_basic();
    test_random();
    test_zero_len();
    test_start_abort();
    test_timeout();
    test_abort();
    test_busy_start_and_reset();
    test_full_table();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
